// File: rtl/ec_point_double_seq.sv
// Sequential projective point doubler for y^2 = x^3 + A*x + B over GF(P).
// One shared modular multiplier is stepped through 13 products by a small FSM.
module ec_point_double_seq #(
   parameter int WIDTH = 4,
   parameter int P     = 7,
   parameter int A     = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] X1,
   input  logic [WIDTH-1:0] Y1,
   input  logic [WIDTH-1:0] Z1,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] X2,
   output logic [WIDTH-1:0] Y2,
   output logic [WIDTH-1:0] Z2
);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   localparam logic [WIDTH:0]     P_E   = (WIDTH+1)'(P);
   localparam logic [2*WIDTH-1:0] P_W   = (2*WIDTH)'(P);
   localparam logic [WIDTH-1:0]   A_R   = WIDTH'(A % P);
   localparam logic [WIDTH-1:0]   ONE_R = WIDTH'(1 % P);
   localparam logic [3:0]         LAST  = 4'd12;

   // Both operands are already in [0, P-1], so one conditional subtract reduces.
   function automatic logic [WIDTH-1:0] add_m(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= P_E) s = s - P_E;
      return s[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] sub_m(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + P_E - {1'b0, b};
      if (s >= P_E) s = s - P_E;
      return s[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] dbl_m(input logic [WIDTH-1:0] a);
      return add_m(a, a);
   endfunction

   function automatic logic [WIDTH-1:0] oct_m(input logic [WIDTH-1:0] a);
      return dbl_m(dbl_m(dbl_m(a)));
   endfunction

   state_t           state;
   logic [3:0]       step;
   logic [WIDTH-1:0] x, y, z;
   logic [WIDTH-1:0] t0, t1, s, w, t3, bv, h, t5, t6, t7;
   logic [WIDTH-1:0] xr, yr, zr;
   logic             res_err;

   logic [WIDTH-1:0]   mul_a, mul_b, r;
   logic [2*WIDTH-1:0] prod;
   logic               bad_operand;

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (step)
         4'd0:    begin mul_a = x;   mul_b = x;  end
         4'd1:    begin mul_a = z;   mul_b = z;  end
         4'd2:    begin mul_a = y;   mul_b = z;  end
         4'd3:    begin mul_a = A_R; mul_b = t1; end
         4'd4:    begin mul_a = x;   mul_b = y;  end
         4'd5:    begin mul_a = t3;  mul_b = s;  end
         4'd6:    begin mul_a = w;   mul_b = w;  end
         4'd7:    begin mul_a = h;   mul_b = s;  end
         4'd8:    begin mul_a = y;   mul_b = y;  end
         4'd9:    begin mul_a = s;   mul_b = s;  end
         4'd10:   begin mul_a = t5;  mul_b = t6; end
         4'd11:   begin mul_a = w;   mul_b = sub_m(dbl_m(dbl_m(bv)), h); end
         4'd12:   begin mul_a = t6;  mul_b = s;  end
         default: begin mul_a = '0;  mul_b = '0; end
      endcase
   end

   assign prod = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
   assign r    = WIDTH'(prod % P_W);

   assign bad_operand = ({1'b0, X1} >= P_E) || ({1'b0, Y1} >= P_E) || ({1'b0, Z1} >= P_E);

   // NOTE: sequential state uses non-blocking assignments only; the synchronous
   // reset clears scratch registers too, so an aborted run leaves nothing behind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         step    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         X2      <= '0;
         Y2      <= '0;
         Z2      <= '0;
         x       <= '0;
         y       <= '0;
         z       <= '0;
         t0      <= '0;
         t1      <= '0;
         s       <= '0;
         w       <= '0;
         t3      <= '0;
         bv      <= '0;
         h       <= '0;
         t5      <= '0;
         t6      <= '0;
         t7      <= '0;
         xr      <= '0;
         yr      <= '0;
         zr      <= '0;
         res_err <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  x    <= X1;
                  y    <= Y1;
                  z    <= Z1;
                  step <= '0;
                  busy <= 1'b1;
                  if (bad_operand) begin
                     res_err <= 1'b1;
                     xr      <= '0;
                     yr      <= '0;
                     zr      <= '0;
                     state   <= FIN;
                  end else if (Z1 == '0 || Y1 == '0) begin
                     res_err <= 1'b0;
                     xr      <= '0;
                     yr      <= ONE_R;
                     zr      <= '0;
                     state   <= FIN;
                  end else begin
                     res_err <= 1'b0;
                     state   <= CALC;
                  end
               end
            end

            CALC: begin
               case (step)
                  4'd0:  t0 <= r;
                  4'd1:  t1 <= r;
                  4'd2:  s  <= r;
                  4'd3:  w  <= add_m(r, add_m(dbl_m(t0), t0));
                  4'd4:  t3 <= r;
                  4'd5:  bv <= r;
                  4'd6:  h  <= sub_m(r, oct_m(bv));
                  4'd7:  xr <= dbl_m(r);
                  4'd8:  t5 <= r;
                  4'd9:  t6 <= r;
                  4'd10: t7 <= r;
                  4'd11: yr <= sub_m(r, oct_m(t7));
                  4'd12: zr <= oct_m(r);
                  default: ;
               endcase
               step <= step + 4'd1;
               if (step == LAST) state <= FIN;
            end

            FIN: begin
               X2    <= xr;
               Y2    <= yr;
               Z2    <= zr;
               err   <= res_err;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
